// File: rtl/idma_desc64_completion_arbiter_if.sv
// rtl/idma_desc64_completion_arbiter_if.sv - completion writeback valid/ready port
//
// Purpose: carries one offered descriptor completion (channel index) from the
//          completion arbiter to the writeback/IRQ logic.
// Signals:
//   valid  arbiter -> consumer   a completion is offered
//   idx    arbiter -> consumer   channel of the offered completion
//   ready  consumer -> arbiter   consumer accepts; handshake = valid & ready
interface idma_desc64_completion_arbiter_if #(
    parameter int unsigned IdxWidth = 2
);
    logic                valid;
    logic [IdxWidth-1:0] idx;
    logic                ready;

    modport master (
        output valid,
        output idx,
        input  ready
    );

    modport slave (
        input  valid,
        input  idx,
        output ready
    );
endinterface

// File: rtl/idma_desc64_completion_arbiter.sv
// rtl/idma_desc64_completion_arbiter.sv - round-robin desc64 completion arbiter
//
// Purpose: counts pending descriptor completions per channel and offers them
//          one at a time, round-robin, on a shared valid/ready writeback port.
// Ports:
//   clk_i             clock
//   rst_ni            asynchronous reset, active low
//   inc_i             per-channel completion pulse (+1 pending)
//   wb                writeback port (master side: valid/idx out, ready in)
//   pending_o         per-channel registered counter != 0
//   overflow_o        sticky per-channel flag: an increment was dropped at max
//   clear_overflow_i  clears all overflow flags next cycle (a new overflow wins)
module idma_desc64_completion_arbiter #(
    parameter int unsigned NumRequesters = 4,
    parameter int unsigned CounterWidth  = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NumRequesters-1:0]             inc_i,
    idma_desc64_completion_arbiter_if.master     wb,
    output logic [NumRequesters-1:0]             pending_o,
    output logic [NumRequesters-1:0]             overflow_o,
    input  logic                                 clear_overflow_i
);

    localparam int unsigned IdxWidth = (NumRequesters > 1) ? $clog2(NumRequesters) : 1;

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StOffer = 1'b1;

    localparam logic [CounterWidth-1:0] CntMax = {CounterWidth{1'b1}};

    logic [0:0]              state_q, state_d;
    logic [CounterWidth-1:0] counter_q [NumRequesters];
    logic [CounterWidth-1:0] counter_d [NumRequesters];
    logic [NumRequesters-1:0] overflow_q, overflow_d;
    logic [NumRequesters-1:0] ovf_set;
    logic [NumRequesters-1:0] dec;
    logic [NumRequesters-1:0] nonzero_q, nonzero_d;
    logic [IdxWidth-1:0]     rr_q, rr_d;
    logic [IdxWidth-1:0]     idx_q, idx_d;
    logic [IdxWidth-1:0]     idx_next;
    logic [IdxWidth-1:0]     winner;
    logic [IdxWidth-1:0]     cand;
    logic                    found;
    logic                    handshake;

    assign handshake = (state_q == StOffer) && wb.ready;

    // Per-channel counters. A simultaneous inc and dec cancel, so a channel
    // sitting at max never loses an increment in its own handshake cycle.
    always_comb begin
        dec     = '0;
        ovf_set = '0;
        for (int i = 0; i < int'(NumRequesters); i++) begin
            dec[i]       = handshake && (idx_q == IdxWidth'(i));
            counter_d[i] = counter_q[i];
            nonzero_q[i] = (counter_q[i] != '0);
            if (inc_i[i] && !dec[i]) begin
                if (counter_q[i] == CntMax) begin
                    ovf_set[i] = 1'b1;
                end else begin
                    counter_d[i] = counter_q[i] + CounterWidth'(1);
                end
            end else if (!inc_i[i] && dec[i]) begin
                counter_d[i] = counter_q[i] - CounterWidth'(1);
            end
            nonzero_d[i] = (counter_d[i] != '0);
        end
        overflow_d = (clear_overflow_i ? '0 : overflow_q) | ovf_set;
    end

    // The pointer only moves past a channel once it has been served, so the
    // search after a handshake starts just beyond the granted channel.
    always_comb begin
        idx_next = (idx_q == IdxWidth'(NumRequesters - 1)) ? '0 : idx_q + IdxWidth'(1);
        rr_d     = handshake ? idx_next : rr_q;
    end

    // First nonzero channel at or after rr_d, wrapping modulo NumRequesters.
    // Arbitration looks at counter_d so a pulse this cycle can be offered next cycle.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int k = 0; k < int'(NumRequesters); k++) begin
            if (int'(rr_d) + k >= int'(NumRequesters)) begin
                cand = IdxWidth'(int'(rr_d) + k - int'(NumRequesters));
            end else begin
                cand = IdxWidth'(int'(rr_d) + k);
            end
            if (!found && nonzero_d[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    // The offered index only changes on a handshake; an offer is never withdrawn.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            StIdle: begin
                if (found) begin
                    state_d = StOffer;
                    idx_d   = winner;
                end
            end
            StOffer: begin
                if (handshake) begin
                    if (found) begin
                        idx_d = winner;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            rr_q       <= '0;
            overflow_q <= '0;
            for (int i = 0; i < int'(NumRequesters); i++) begin
                counter_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            rr_q       <= rr_d;
            overflow_q <= overflow_d;
            for (int i = 0; i < int'(NumRequesters); i++) begin
                counter_q[i] <= counter_d[i];
            end
        end
    end

    assign wb.valid   = (state_q == StOffer);
    assign wb.idx     = idx_q;
    assign pending_o  = nonzero_q;
    assign overflow_o = overflow_q;

    // An offered channel always holds at least one pending completion.
    dec_never_at_zero: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (dec & ~nonzero_q) == '0);

endmodule

// File: tb/tb_idma_desc64_completion_arbiter.sv
// tb/tb_idma_desc64_completion_arbiter.sv - bench for idma_desc64_completion_arbiter
module tb_idma_desc64_completion_arbiter;

    logic       clk    = 1'b0;
    logic       rst_ni = 1'b0;
    logic [3:0] inc    = 4'b0000;
    logic       clr    = 1'b0;
    logic [3:0] pending;
    logic [3:0] overflow;

    idma_desc64_completion_arbiter_if #(.IdxWidth(2)) wb_if ();

    idma_desc64_completion_arbiter #(
        .NumRequesters (4),
        .CounterWidth  (4)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .inc_i            (inc),
        .wb               (wb_if),
        .pending_o        (pending),
        .overflow_o       (overflow),
        .clear_overflow_i (clr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int unsigned sb[$];

    typedef struct {
        logic [3:0] inc;
        logic       ready;
        logic       clr;
        logic       exp_valid;
        logic [1:0] exp_idx;
        logic [3:0] exp_pend;
        logic [3:0] exp_ovf;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scores a handshake about to complete at the coming edge, then advances
    // to just after that edge.
    task automatic cycle();
        int unsigned e;
        if (wb_if.valid === 1'b1 && wb_if.ready === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got grant idx %0d, expected no grant", wb_if.idx);
            end else begin
                e = sb.pop_front();
                if (wb_if.idx !== 2'(e)) begin
                    errors++;
                    $display("FAIL sb_grant: got idx %0d, expected %0d", wb_if.idx, e);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (sb.size() > 0 && n < budget) begin
            cycle();
            n++;
        end
        chk(name, sb.size(), 0);
    endtask

    task automatic do_reset();
        rst_ni      = 1'b0;
        inc         = 4'b0000;
        clr         = 1'b0;
        wb_if.ready = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_valid", wb_if.valid, 1'b0);
        chk("rst_idx", wb_if.idx, 2'd0);
        chk("rst_pending", pending, 4'b0000);
        chk("rst_overflow", overflow, 4'b0000);
        rst_ni = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000};
        vecs[1]  = '{4'b0100, 1'b1, 1'b0, 1'b1, 2'd2, 4'b0100, 4'b0000};
        vecs[2]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd2, 4'b0000, 4'b0000};
        vecs[3]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 2'd2, 4'b0000, 4'b0000};
        vecs[4]  = '{4'b1011, 1'b0, 1'b0, 1'b1, 2'd3, 4'b1011, 4'b0000};
        vecs[5]  = '{4'b0001, 1'b0, 1'b0, 1'b1, 2'd3, 4'b1011, 4'b0000};
        vecs[6]  = '{4'b0000, 1'b1, 1'b0, 1'b1, 2'd0, 4'b0011, 4'b0000};
        vecs[7]  = '{4'b0000, 1'b1, 1'b0, 1'b1, 2'd1, 4'b0011, 4'b0000};
        vecs[8]  = '{4'b0000, 1'b1, 1'b0, 1'b1, 2'd0, 4'b0001, 4'b0000};
        vecs[9]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000};
        vecs[10] = '{4'b0010, 1'b0, 1'b1, 1'b1, 2'd1, 4'b0010, 4'b0000};
        vecs[11] = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd1, 4'b0000, 4'b0000};

        wb_if.ready = 1'b0;
        do_reset();

        // Table: single completion, then rr continuing from the served channel.
        sb.push_back(2); sb.push_back(3); sb.push_back(0);
        sb.push_back(1); sb.push_back(0); sb.push_back(1);
        for (int r = 0; r < 12; r++) begin
            inc         = vecs[r].inc;
            wb_if.ready = vecs[r].ready;
            clr         = vecs[r].clr;
            cycle();
            chk($sformatf("vec%0d_valid", r), wb_if.valid, vecs[r].exp_valid);
            chk($sformatf("vec%0d_idx", r), wb_if.idx, vecs[r].exp_idx);
            chk($sformatf("vec%0d_pending", r), pending, vecs[r].exp_pend);
            chk($sformatf("vec%0d_overflow", r), overflow, vecs[r].exp_ovf);
        end
        inc = 4'b0000; clr = 1'b0; wb_if.ready = 1'b0;
        chk("vec_sb_empty", sb.size(), 0);

        // Preloaded counts drain 0,1,3,0 back to back.
        do_reset();
        inc = 4'b1011; cycle();
        inc = 4'b0001; cycle();
        inc = 4'b0000;
        chk("t2_valid", wb_if.valid, 1'b1);
        chk("t2_idx", wb_if.idx, 2'd0);
        chk("t2_pending", pending, 4'b1011);
        sb.push_back(0); sb.push_back(1); sb.push_back(3); sb.push_back(0);
        wb_if.ready = 1'b1;
        drain("t2_back_to_back", 4);
        chk("t2_idle", wb_if.valid, 1'b0);
        chk("t2_pending_end", pending, 4'b0000);

        // Stalled offer on ch1 stays stable while others accumulate.
        wb_if.ready = 1'b0;
        inc = 4'b0010; cycle();
        chk("t3_offer_idx", wb_if.idx, 2'd1);
        for (int j = 0; j < 5; j++) begin
            inc = (j % 2 == 1) ? 4'b1000 : 4'b0101;
            cycle();
            chk($sformatf("t3_hold_valid%0d", j), wb_if.valid, 1'b1);
            chk($sformatf("t3_hold_idx%0d", j), wb_if.idx, 2'd1);
        end
        inc = 4'b0000;
        chk("t3_pending", pending, 4'b1111);
        sb.push_back(1); sb.push_back(2); sb.push_back(3); sb.push_back(0);
        sb.push_back(2); sb.push_back(3); sb.push_back(0); sb.push_back(2);
        sb.push_back(0);
        wb_if.ready = 1'b1;
        drain("t3_drain", 9);
        chk("t3_idle", wb_if.valid, 1'b0);

        // Saturation at 15, sticky overflow, set beats clear, then drain 15.
        do_reset();
        inc = 4'b0001;
        for (int j = 0; j < 16; j++) cycle();
        chk("t4_overflow", overflow, 4'b0001);
        chk("t4_pending", pending, 4'b0001);
        clr = 1'b1; cycle();
        chk("t4_set_wins", overflow, 4'b0001);
        inc = 4'b0000; cycle();
        chk("t4_cleared", overflow, 4'b0000);
        clr = 1'b0;
        for (int j = 0; j < 15; j++) sb.push_back(0);
        wb_if.ready = 1'b1;
        drain("t4_drain15", 15);
        chk("t4_idle", wb_if.valid, 1'b0);
        chk("t4_pending_end", pending, 4'b0000);

        // Inc in the handshake cycle keeps ch2 pending but rr moves past it.
        wb_if.ready = 1'b0;
        inc = 4'b0100; cycle();
        chk("t5_offer_idx", wb_if.idx, 2'd2);
        inc = 4'b1001; cycle();
        inc = 4'b0100; wb_if.ready = 1'b1;
        sb.push_back(2);
        cycle();
        inc = 4'b0000;
        chk("t5_pending", pending, 4'b1101);
        chk("t5_next_idx", wb_if.idx, 2'd3);
        sb.push_back(3); sb.push_back(0); sb.push_back(2);
        drain("t5_drain", 3);
        chk("t5_idle", wb_if.valid, 1'b0);

        // Asynchronous reset mid-offer.
        wb_if.ready = 1'b0;
        inc = 4'b0011; cycle();
        inc = 4'b0001;
        for (int j = 0; j < 16; j++) cycle();
        inc = 4'b0000;
        chk("t6_pre_overflow", overflow, 4'b0001);
        chk("t6_pre_valid", wb_if.valid, 1'b1);
        #2;
        rst_ni = 1'b0;
        wb_if.ready = 1'b1;
        #1;
        chk("t6_async_valid", wb_if.valid, 1'b0);
        chk("t6_async_pending", pending, 4'b0000);
        chk("t6_async_overflow", overflow, 4'b0000);
        chk("t6_async_idx", wb_if.idx, 2'd0);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        wb_if.ready = 1'b0;
        cycle();
        chk("t6_after_valid", wb_if.valid, 1'b0);
        chk("t6_after_pending", pending, 4'b0000);
        chk("sb_final_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
